// File: rtl/sme_arb_if.sv
// ============================================================================
// sme_arb_if : requester, matcher and response signals of the SME arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface sme_arb_if;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic [7:0] cd0, cd1;
  logic       isstr0, isstr1, ispat0, ispat1;
  logic [7:0] sme_chardata;
  logic       sme_isstring, sme_ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_match_index;
  logic       sme_rst;
  logic       rsp_valid, rsp_id, rsp_match;
  logic [4:0] rsp_index;
  logic [1:0] rsp_err;

  modport slave (
    input  req0, req1, cd0, cd1, isstr0, isstr1, ispat0, ispat1,
    input  sme_valid, sme_match, sme_match_index,
    output gnt0, gnt1, sme_chardata, sme_isstring, sme_ispattern, sme_rst,
    output rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );

  modport master (
    output req0, req1, cd0, cd1, isstr0, isstr1, ispat0, ispat1,
    output sme_valid, sme_match, sme_match_index,
    input  gnt0, gnt1, sme_chardata, sme_isstring, sme_ispattern, sme_rst,
    input  rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/sme_arb.sv
// ============================================================================
// sme_arb : two-requester round-robin arbiter feeding one string matcher
// Rev 1.0
// ============================================================================
`default_nettype none

module sme_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  sme_arb_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XFER  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
  localparam logic [5:0] c_str_max   = 6'd32;
  localparam logic [3:0] c_pat_max   = 4'd8;
  localparam logic [1:0] c_err_ok    = 2'd0;
  localparam logic [1:0] c_err_proto = 2'd1;
  localparam logic [1:0] c_err_tmo   = 2'd2;

  state_t     r_state;
  logic       r_owner;
  logic       r_last;
  logic [5:0] r_str_cnt;
  logic [3:0] r_pat_cnt;
  logic [7:0] r_cnt;
  logic       r_gnt0, r_gnt1;
  logic [7:0] r_sme_char;
  logic       r_sme_str, r_sme_pat, r_sme_rst;
  logic       r_rsp_valid, r_rsp_id, r_rsp_match;
  logic [4:0] r_rsp_index;
  logic [1:0] r_rsp_err;

  logic [7:0] w_cd;
  logic       w_s, w_p;
  logic       w_pick;
  logic [7:0] w_cnt_inc;
  logic       w_cnt_hit;
  logic       w_fwd, w_end, w_to_wait;
  logic [1:0] w_err;
  logic [7:0] w_cnt_next;

  assign w_cd      = r_owner ? bus.cd1    : bus.cd0;
  assign w_s       = r_owner ? bus.isstr1 : bus.isstr0;
  assign w_p       = r_owner ? bus.ispat1 : bus.ispat0;
  // r_last names the requester served most recently; it loses a tie
  assign w_pick    = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_cnt_hit = (w_cnt_inc == c_timeout);

  always_comb begin
    w_fwd      = 1'b0;
    w_end      = 1'b0;
    w_err      = c_err_ok;
    w_to_wait  = 1'b0;
    w_cnt_next = r_cnt;
    case (r_state)
      S_XFER: begin
        if (w_s && w_p) begin
          w_end = 1'b1; w_err = c_err_proto;
        end else if (r_pat_cnt != 4'd0) begin
          if (w_s || (w_p && r_pat_cnt == c_pat_max)) begin
            w_end = 1'b1; w_err = c_err_proto;
          end else if (w_p) begin
            w_fwd = 1'b1;
          end else begin
            w_to_wait  = 1'b1;
            w_cnt_next = 8'd0;
          end
        end else if (r_str_cnt != 6'd0) begin
          // a silent cycle here is the forbidden string/pattern gap
          if (w_p) begin
            w_fwd = 1'b1;
          end else if (!w_s || r_str_cnt == c_str_max) begin
            w_end = 1'b1; w_err = c_err_proto;
          end else begin
            w_fwd = 1'b1;
          end
        end else if (w_p) begin
          w_end = 1'b1; w_err = c_err_proto;
        end else if (w_s) begin
          w_fwd = 1'b1;
        end else if (w_cnt_hit) begin
          w_end = 1'b1; w_err = c_err_tmo;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_WAIT: begin
        if (bus.sme_valid) begin
          w_end = 1'b1;
        end else if (w_cnt_hit) begin
          w_end = 1'b1; w_err = c_err_tmo;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_str_cnt   <= 6'd0;
      r_pat_cnt   <= 4'd0;
      r_cnt       <= 8'd0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_sme_char  <= 8'd0;
      r_sme_str   <= 1'b0;
      r_sme_pat   <= 1'b0;
      r_sme_rst   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_match <= 1'b0;
      r_rsp_index <= 5'd0;
      r_rsp_err   <= 2'd0;
    end else begin
      r_sme_char  <= 8'd0;
      r_sme_str   <= 1'b0;
      r_sme_pat   <= 1'b0;
      r_sme_rst   <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_owner <= w_pick;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_str_cnt <= 6'd0;
          r_pat_cnt <= 4'd0;
          r_cnt     <= 8'd0;
          r_state   <= S_XFER;
        end
        S_XFER, S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (w_fwd) begin
            r_sme_char <= w_cd;
            r_sme_str  <= w_s;
            r_sme_pat  <= w_p;
            r_str_cnt  <= r_str_cnt + {5'd0, w_s};
            r_pat_cnt  <= r_pat_cnt + {3'd0, w_p};
          end
          if (w_to_wait) begin
            r_state <= S_WAIT;
          end
          if (w_end) begin
            r_state     <= S_RESP;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_owner;
            r_rsp_err   <= w_err;
            r_sme_rst   <= (w_err != c_err_ok);
            r_rsp_match <= (w_err == c_err_ok) && bus.sme_match;
            r_rsp_index <= (w_err == c_err_ok) ? bus.sme_match_index : 5'd0;
          end
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0          = r_gnt0;
  assign bus.gnt1          = r_gnt1;
  assign bus.sme_chardata  = r_sme_char;
  assign bus.sme_isstring  = r_sme_str;
  assign bus.sme_ispattern = r_sme_pat;
  assign bus.sme_rst       = r_sme_rst;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_match     = r_rsp_match;
  assign bus.rsp_index     = r_rsp_index;
  assign bus.rsp_err       = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_sme_arb.sv
// ============================================================================
// tb_sme_arb : directed self-checking bench for sme_arb (TIMEOUT = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sme_arb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sme_arb_if bus ();
  sme_arb #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] str_buf [0:39];
  logic [7:0] pat_buf [0:9];
  logic [7:0] seqs [0:2];
  int         lens [0:2];
  logic [7:0] cur_seq;
  logic [1:0] sp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic v);
    if (who) bus.req1 = v; else bus.req0 = v;
  endtask

  // owner gets the byte, the other requester gets noise that must be ignored
  task automatic set_bytes(input logic who, input logic [7:0] c, input logic s, input logic p);
    if (!who) begin
      bus.cd0 = c;  bus.isstr0 = s; bus.ispat0 = p;
      bus.cd1 = ~c; bus.isstr1 = p; bus.ispat1 = s;
    end else begin
      bus.cd1 = c;  bus.isstr1 = s; bus.ispat1 = p;
      bus.cd0 = ~c; bus.isstr0 = p; bus.ispat0 = s;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({bus.gnt0, bus.gnt1, bus.sme_chardata, bus.sme_isstring, bus.sme_ispattern,
                    bus.sme_rst, bus.rsp_valid, bus.rsp_id, bus.rsp_match, bus.rsp_index,
                    bus.rsp_err}), 32'd0);
  endtask

  // request already raised, state IDLE: grant, drop request, enter XFER
  task automatic enter_xfer(input logic who);
    tick;
    check("gnt_owner", 32'({bus.gnt1, bus.gnt0}), who ? 32'd2 : 32'd1);
    set_req(who, 1'b0);
    tick;
  endtask

  task automatic send_stream(input logic who, input int nstr, input int npat);
    for (int i = 0; i < nstr; i++) begin
      set_bytes(who, str_buf[i], 1'b1, 1'b0);
      tick;
      check("fwd_str", 32'({bus.sme_chardata, bus.sme_isstring, bus.sme_ispattern}),
            32'({str_buf[i], 2'b10}));
    end
    for (int i = 0; i < npat; i++) begin
      set_bytes(who, pat_buf[i], 1'b0, 1'b1);
      tick;
      check("fwd_pat", 32'({bus.sme_chardata, bus.sme_isstring, bus.sme_ispattern}),
            32'({pat_buf[i], 2'b01}));
    end
    set_bytes(who, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic to_wait(input logic who, input int nstr, input int npat);
    enter_xfer(who);
    send_stream(who, nstr, npat);
    tick;
    check("wait_quiet", 32'({bus.sme_chardata, bus.sme_isstring, bus.sme_ispattern, bus.rsp_valid}), 32'd0);
    check("wait_gnt", 32'({bus.gnt1, bus.gnt0}), who ? 32'd2 : 32'd1);
  endtask

  task automatic finish_ok(input logic who, input logic m, input logic [4:0] idx);
    bus.sme_valid = 1'b1; bus.sme_match = m; bus.sme_match_index = idx;
    tick;
    bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_match_index = 5'd0;
    check("rsp_ok", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_match, bus.rsp_index, bus.rsp_err,
                         bus.sme_rst, bus.gnt1, bus.gnt0}),
          32'({1'b1, who, m, idx, 2'd0, 3'b000}));
    tick;
    check("rsp_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_match, bus.rsp_index, bus.rsp_err}),
          32'({1'b0, who, m, idx, 2'd0}));
  endtask

  // called just after the aborting edge; inputs for the next cycle already set
  task automatic expect_abort(input string tag, input logic [1:0] err, input logic who);
    check(tag, 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_match, bus.rsp_index, bus.rsp_err,
                    bus.sme_rst, bus.gnt1, bus.gnt0, bus.sme_isstring, bus.sme_ispattern}),
          32'({1'b1, who, 1'b0, 5'd0, err, 1'b1, 4'b0000}));
    tick;
    check({tag, "_after"}, 32'({bus.rsp_valid, bus.sme_rst, bus.sme_isstring, bus.sme_ispattern,
                                bus.rsp_err}), 32'({4'b0000, err}));
    set_bytes(who, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.cd0 = 8'h00; bus.cd1 = 8'h00;
    bus.isstr0 = 1'b0; bus.isstr1 = 1'b0; bus.ispat0 = 1'b0; bus.ispat1 = 1'b0;
    bus.sme_valid = 1'b0; bus.sme_match = 1'b0; bus.sme_match_index = 5'd0;
    seqs[0] = 8'b0000_0011; lens[0] = 1;   // isstr and ispat together
    seqs[1] = 8'b0000_0001; lens[1] = 1;   // pattern before any string
    seqs[2] = 8'b0010_0110; lens[2] = 3;   // string, pattern, string again

    tick; tick;
    check_all_zero("reset_state");
    reset = 1'b1;
    tick;

    // "ab cd" / "cd", matcher reports match at index 3
    str_buf[0] = "a"; str_buf[1] = "b"; str_buf[2] = " "; str_buf[3] = "c"; str_buf[4] = "d";
    pat_buf[0] = "c"; pat_buf[1] = "d";
    bus.req0 = 1'b1;
    to_wait(1'b0, 5, 2);
    finish_ok(1'b0, 1'b1, 5'd3);

    for (int i = 0; i < 40; i++) str_buf[i] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) pat_buf[i] = 8'h61 + 8'(i);

    // round robin from a fresh reset
    reset = 1'b0; tick; reset = 1'b1; tick;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    to_wait(1'b0, 2, 1); finish_ok(1'b0, 1'b0, 5'd7);
    to_wait(1'b1, 3, 2); finish_ok(1'b1, 1'b1, 5'd31);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    to_wait(1'b0, 1, 1); finish_ok(1'b0, 1'b1, 5'd0);
    to_wait(1'b1, 1, 1); finish_ok(1'b1, 1'b0, 5'd2);

    // gap between string and pattern; the pattern byte must not reach the matcher
    bus.req0 = 1'b1;
    enter_xfer(1'b0);
    send_stream(1'b0, 1, 0);
    tick;
    set_bytes(1'b0, 8'h61, 1'b0, 1'b1);
    expect_abort("gap_err", 2'd1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      bus.req1 = 1'b1;
      enter_xfer(1'b1);
      cur_seq = seqs[k];
      for (int i = 0; i < lens[k]; i++) begin
        sp = cur_seq[2*i +: 2];
        set_bytes(1'b1, 8'h30 + 8'(i), sp[1], sp[0]);
        tick;
      end
      set_bytes(1'b1, 8'h00, 1'b0, 1'b0);
      expect_abort("proto_seq", 2'd1, 1'b1);
    end

    // 33rd string byte
    bus.req0 = 1'b1;
    enter_xfer(1'b0);
    send_stream(1'b0, 32, 0);
    set_bytes(1'b0, str_buf[32], 1'b1, 1'b0);
    tick;
    set_bytes(1'b0, 8'h00, 1'b0, 1'b0);
    expect_abort("str33_err", 2'd1, 1'b0);

    // 8 pattern bytes accepted, 9th rejected
    bus.req0 = 1'b1;
    to_wait(1'b0, 1, 8); finish_ok(1'b0, 1'b1, 5'd8);
    bus.req0 = 1'b1;
    enter_xfer(1'b0);
    send_stream(1'b0, 1, 8);
    set_bytes(1'b0, pat_buf[8], 1'b0, 1'b1);
    tick;
    set_bytes(1'b0, 8'h00, 1'b0, 1'b0);
    expect_abort("pat9_err", 2'd1, 1'b0);

    // matcher silent for 4 WAIT cycles
    bus.req1 = 1'b1;
    to_wait(1'b1, 2, 1);
    tick; tick; tick;
    check("wait_tmo_early", 32'(bus.rsp_valid), 32'd0);
    tick;
    expect_abort("wait_tmo", 2'd2, 1'b1);

    // matcher answers on the 4th WAIT cycle: result beats the timeout
    bus.req1 = 1'b1;
    to_wait(1'b1, 2, 1);
    tick; tick; tick;
    finish_ok(1'b1, 1'b1, 5'd5);

    // no string byte ever arrives
    bus.req0 = 1'b1;
    enter_xfer(1'b0);
    tick; tick; tick;
    check("idle_tmo_early", 32'(bus.rsp_valid), 32'd0);
    tick;
    expect_abort("idle_tmo", 2'd2, 1'b0);

    // asynchronous reset in the middle of WAIT
    bus.req0 = 1'b1;
    to_wait(1'b0, 1, 1);
    tick;
    #2 reset = 1'b0;
    #1 check_all_zero("reset_async");
    bus.sme_valid = 1'b1;
    tick;
    check_all_zero("reset_held");
    reset = 1'b1;
    bus.sme_valid = 1'b0;
    tick;
    check_all_zero("reset_release");
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    to_wait(1'b0, 2, 2);
    finish_ok(1'b0, 1'b1, 5'd9);
    bus.req1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
